// File: rtl/fft_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fft_seq_pkg
//  Purpose  : Shared types and width helpers for the FFT stage sequencer.
//             Holds the sequencer state encoding and the functions that
//             derive bus widths from the frame size / in-flight limit.
//  Revision : 1.0  initial release
// ============================================================================
package fft_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fft_seq_state_e;

  // Number of radix-2 stages; also the sample address width.
  function automatic int fft_log2(input int size_fft);
    return $clog2(size_fft);
  endfunction

  // Stage index width; kept at least one bit so the field always exists.
  function automatic int fft_stage_w(input int size_fft);
    int l;
    l = $clog2(size_fft);
    return ($clog2(l) < 1) ? 1 : $clog2(l);
  endfunction

  // Butterfly index / twiddle index width (SIZE_FFT/2 values).
  function automatic int fft_k_w(input int size_fft);
    return $clog2(size_fft) - 1;
  endfunction

  // Outstanding counter width: must hold 0..MAX_OUTSTANDING inclusive.
  function automatic int fft_out_w(input int max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_stage_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : fft_stage_sequencer_if
//  Purpose  : Handshake bundle between the FFT stage sequencer and its
//             environment (frame buffer, butterfly datapath, consumer).
//  Ports    : master = sequencer side, slave = environment side.
//             start_val/start_rdy  frame start handshake
//             cmd_*                butterfly command (val/rdy + fields)
//             wb_val               one pulse per butterfly write-back
//             done_val/done_rdy    frame completion handshake
//             busy, err            status
//  Revision : 1.0  initial release
// ============================================================================
interface fft_stage_sequencer_if #(
  parameter int SIZE_FFT = 8
);
  import fft_seq_pkg::*;

  localparam int ADDR_W  = fft_log2(SIZE_FFT);
  localparam int STAGE_W = fft_stage_w(SIZE_FFT);
  localparam int K_W     = fft_k_w(SIZE_FFT);

  logic               start_val;
  logic               start_rdy;
  logic               cmd_val;
  logic               cmd_rdy;
  logic [STAGE_W-1:0] cmd_stage;
  logic [ADDR_W-1:0]  cmd_addr_a;
  logic [ADDR_W-1:0]  cmd_addr_b;
  logic [K_W-1:0]     cmd_twiddle;
  logic               wb_val;
  logic               done_val;
  logic               done_rdy;
  logic               busy;
  logic               err;

  modport master (
    input  start_val, cmd_rdy, wb_val, done_rdy,
    output start_rdy, cmd_val, cmd_stage, cmd_addr_a, cmd_addr_b,
           cmd_twiddle, done_val, busy, err
  );

  modport slave (
    output start_val, cmd_rdy, wb_val, done_rdy,
    input  start_rdy, cmd_val, cmd_stage, cmd_addr_a, cmd_addr_b,
           cmd_twiddle, done_val, busy, err
  );

endinterface
`default_nettype wire

// File: rtl/fft_bfly_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : fft_bfly_addr_gen
//  Purpose  : Combinational map from (stage, butterfly index k) to the two
//             in-place sample addresses and the twiddle-table index of a
//             radix-2 DIT butterfly.
//  Ports    : stage    in  stage s, 0..L-1
//             k        in  butterfly index within the stage
//             addr_a   out top sample address
//             addr_b   out bottom sample address (addr_a + 2^s)
//             twiddle  out twiddle index, j << (L-1-s)
//  Revision : 1.0  initial release
// ============================================================================
module fft_bfly_addr_gen
  import fft_seq_pkg::*;
#(
  parameter  int SIZE_FFT = 8,
  localparam int L        = fft_log2(SIZE_FFT),
  localparam int ADDR_W   = L,
  localparam int STAGE_W  = fft_stage_w(SIZE_FFT),
  localparam int K_W      = fft_k_w(SIZE_FFT)
) (
  input  logic [STAGE_W-1:0] stage,
  input  logic [K_W-1:0]     k,
  output logic [ADDR_W-1:0]  addr_a,
  output logic [ADDR_W-1:0]  addr_b,
  output logic [K_W-1:0]     twiddle
);

  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(L - 1);

  logic [K_W-1:0]     low_mask;
  logic [K_W-1:0]     j;
  logic [K_W-1:0]     g_shifted;
  logic [ADDR_W-1:0]  span;
  logic [STAGE_W-1:0] tw_shift;

  always_comb begin
    // low_mask = span-1 computed in K_W bits: the top stage has span = 2^(L-1)
    // which would not fit, but its mask (all ones) does.
    low_mask  = ~({K_W{1'b1}} << stage);
    j         = k & low_mask;
    // (k >> s) << s keeps the group bits in place; one more shift inserts
    // the zero that separates the top and bottom halves of the group.
    g_shifted = k & ~low_mask;
    span      = ADDR_W'(1) << stage;
    tw_shift  = STAGE_LAST - stage;
    addr_a    = {g_shifted, 1'b0} | {1'b0, j};
    addr_b    = addr_a + span;
    twiddle   = j << tw_shift;
  end

endmodule
`default_nettype wire

// File: rtl/fft_stage_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fft_stage_sequencer
//  Purpose  : Sequences one in-place radix-2 DIT FFT frame. After a start
//             handshake it issues SIZE_FFT/2 butterfly commands per stage,
//             caps the butterflies in flight at MAX_OUTSTANDING, and holds a
//             barrier between stages until every write-back has returned.
//  Ports    : clk    rising-edge clock
//             reset  asynchronous, active-high
//             bus    fft_stage_sequencer_if.master (start/cmd/wb/done, status)
//  Revision : 1.0  initial release
// ============================================================================
module fft_stage_sequencer
  import fft_seq_pkg::*;
#(
  parameter int SIZE_FFT        = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  fft_stage_sequencer_if.master         bus
);

  localparam int L       = fft_log2(SIZE_FFT);
  localparam int ADDR_W  = L;
  localparam int STAGE_W = fft_stage_w(SIZE_FFT);
  localparam int K_W     = fft_k_w(SIZE_FFT);
  localparam int OUT_W   = fft_out_w(MAX_OUTSTANDING);

  localparam logic [K_W-1:0]     K_LAST     = K_W'(SIZE_FFT / 2 - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(L - 1);
  localparam logic [OUT_W-1:0]   OUT_MAX    = OUT_W'(MAX_OUTSTANDING);

  fft_seq_state_e     state_q, state_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               err_q, err_d;

  logic               cmd_val_w;
  logic               fire_w;
  logic               wb_counted_w;
  logic               idle_w;

  logic [ADDR_W-1:0]  gen_addr_a;
  logic [ADDR_W-1:0]  gen_addr_b;
  logic [K_W-1:0]     gen_twiddle;

  fft_bfly_addr_gen #(
    .SIZE_FFT (SIZE_FFT)
  ) u_addr_gen (
    .stage   (stage_q),
    .k       (k_q),
    .addr_a  (gen_addr_a),
    .addr_b  (gen_addr_b),
    .twiddle (gen_twiddle)
  );

  // cmd_val depends only on registered state, never on cmd_rdy.
  assign cmd_val_w = (state_q == ISSUE) && (out_q < OUT_MAX);
  assign fire_w    = cmd_val_w && bus.cmd_rdy;
  assign idle_w    = (state_q == IDLE);

  // A write-back only retires a butterfly if one exists; a write-back that
  // coincides with a fire at zero outstanding cancels against that fire.
  assign wb_counted_w = bus.wb_val && ((out_q != '0) || fire_w);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    stage_d = stage_q;
    out_d   = out_q;
    err_d   = err_q;

    if (fire_w && !wb_counted_w) begin
      out_d = out_q + OUT_W'(1);
    end else if (!fire_w && wb_counted_w) begin
      out_d = out_q - OUT_W'(1);
    end

    if (bus.wb_val && (out_q == '0) && !fire_w) begin
      err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.start_val) begin
          stage_d = '0;
          k_d     = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (fire_w) begin
          // k stays on the last butterfly through DRAIN; the fields are
          // meaningless while cmd_val is low.
          if (k_q == K_LAST) begin
            state_d = DRAIN;
          end else begin
            k_d = k_q + K_W'(1);
          end
        end
      end
      DRAIN: begin
        // Using out_d lets a write-back in this cycle release the barrier
        // so the next stage starts on the following cycle.
        if (out_d == '0) begin
          if (stage_q != STAGE_LAST) begin
            stage_d = stage_q + STAGE_W'(1);
            k_d     = '0;
            state_d = ISSUE;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.done_rdy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      stage_q <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      stage_q <= stage_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign bus.start_rdy   = idle_w;
  assign bus.cmd_val     = cmd_val_w;
  assign bus.done_val    = (state_q == DONE);
  assign bus.busy        = !idle_w;
  assign bus.err         = err_q;

  // Fields read as zero while idle so a reset sequencer presents an all-zero
  // command; otherwise they track the current stage/k.
  assign bus.cmd_stage   = idle_w ? '0 : stage_q;
  assign bus.cmd_addr_a  = idle_w ? '0 : gen_addr_a;
  assign bus.cmd_addr_b  = idle_w ? '0 : gen_addr_b;
  assign bus.cmd_twiddle = idle_w ? '0 : gen_twiddle;

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_stage_sequencer
//  Purpose  : Self-checking bench for fft_stage_sequencer. Expected butterfly
//             commands are queued per frame; a monitor pops and compares on
//             every fire. A responder returns write-backs after a delay.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fft_stage_sequencer;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fft_stage_sequencer_if #(.SIZE_FFT(8)) bus ();
  fft_stage_sequencer #(
    .SIZE_FFT        (8),
    .MAX_OUTSTANDING (4)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Wider frame so a stage has more butterflies than the in-flight limit.
  fft_stage_sequencer_if #(.SIZE_FFT(16)) bus16 ();
  fft_stage_sequencer #(
    .SIZE_FFT        (16),
    .MAX_OUTSTANDING (4)
  ) u_dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16)
  );

  typedef struct {
    int stage;
    int a;
    int b;
    int tw;
  } cmd_t;

  cmd_t exp_q[$];
  int   wb_due[$];
  int   fire_cyc[$];
  int   wb_cyc[$];

  int   cyc        = 0;
  int   errors     = 0;
  int   checks     = 0;
  int   fire_count = 0;
  int   fires16    = 0;
  int   done_cyc   = -1;
  int   auto_limit = 1000;
  int   slow_fire  = -1;
  bit   done_prev  = 1'b0;
  bit   hold_pend  = 1'b0;
  int   hold_a, hold_b, hold_tw, hold_s;

  int   tbl_a [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int   tbl_b [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int   tbl_tw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_frame();
    cmd_t e;
    for (int i = 0; i < 12; i++) begin
      e.stage = i / 4;
      e.a     = tbl_a[i];
      e.b     = tbl_b[i];
      e.tw    = tbl_tw[i];
      exp_q.push_back(e);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor: scoreboard pop on every fire, hold-stability, done timing.
  initial begin
    cmd_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (hold_pend && bus.cmd_val) begin
          chk("hold_addr_a", int'(bus.cmd_addr_a), hold_a);
          chk("hold_addr_b", int'(bus.cmd_addr_b) * 100 + int'(bus.cmd_twiddle) * 10
              + int'(bus.cmd_stage), hold_b * 100 + hold_tw * 10 + hold_s);
        end
        hold_pend = bus.cmd_val && !bus.cmd_rdy;
        hold_a    = int'(bus.cmd_addr_a);
        hold_b    = int'(bus.cmd_addr_b);
        hold_tw   = int'(bus.cmd_twiddle);
        hold_s    = int'(bus.cmd_stage);
        if (bus.cmd_val && bus.cmd_rdy) begin
          fire_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_cmd: got a=%0d b=%0d with nothing expected", bus.cmd_addr_a, bus.cmd_addr_b);
          end else begin
            e = exp_q.pop_front();
            chk("cmd_stage",   int'(bus.cmd_stage),   e.stage);
            chk("cmd_addr_a",  int'(bus.cmd_addr_a),  e.a);
            chk("cmd_addr_b",  int'(bus.cmd_addr_b),  e.b);
            chk("cmd_twiddle", int'(bus.cmd_twiddle), e.tw);
          end
          if (fire_count < auto_limit) begin
            wb_due.push_back(cyc + ((fire_count == slow_fire) ? 12 : 2));
          end
          fire_count++;
        end
        if (bus.done_val && !done_prev && done_cyc < 0) begin
          done_cyc = cyc;
        end
        done_prev = bus.done_val;
      end
      if (bus16.cmd_val && bus16.cmd_rdy) begin
        fires16++;
      end
    end
  end

  // Write-back responder: one pulse per cycle for the oldest due entry.
  initial begin
    bit hit;
    bus.wb_val = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.wb_val = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < wb_due.size(); i++) begin
        if (!hit && wb_due[i] <= cyc) begin
          hit = 1'b1;
          bus.wb_val = 1'b1;
          wb_cyc.push_back(cyc);
          wb_due.delete(i);
        end
      end
    end
  end

  task automatic start_frame();
    bus.start_val = 1'b1;
    @(negedge clk);
    chk("start_accept", int'(bus.start_rdy), 1);
    @(posedge clk);
    #1;
    bus.start_val = 1'b0;
    @(negedge clk);
    chk("first_cmd_latency", int'(bus.cmd_val), 1);
  endtask

  task automatic run_frame(input int bp_after, input int slow, input bit chk_tput);
    bit bp_done;
    fire_count = 0;
    fire_cyc.delete();
    wb_cyc.delete();
    wb_due.delete();
    done_cyc   = -1;
    slow_fire  = slow;
    auto_limit = 1000;
    bp_done    = 1'b0;
    push_frame();
    start_frame();
    for (int n = 0; n < 200 && done_cyc < 0; n++) begin
      @(posedge clk);
      #1;
      if (bp_after >= 0 && !bp_done && fire_count == bp_after) begin
        bus.cmd_rdy = 1'b0;
        repeat (5) begin
          @(posedge clk);
          #1;
        end
        bus.cmd_rdy = 1'b1;
        bp_done = 1'b1;
      end
    end
    chk("done_seen", int'(done_cyc >= 0), 1);
    chk("fire_total", fire_count, 12);
    chk("exp_left", exp_q.size(), 0);
    if (wb_cyc.size() == 12 && fire_cyc.size() == 12) begin
      chk("done_latency", done_cyc, wb_cyc[11] + 1);
      chk("barrier_s0", int'(fire_cyc[4] >= wb_cyc[3] + 1), 1);
      chk("barrier_s1", int'(fire_cyc[8] >= wb_cyc[7] + 1), 1);
      if (chk_tput) begin
        chk("throughput", fire_cyc[3] - fire_cyc[0], 3);
      end
      if (slow >= 0) begin
        chk("slow_wb_delay", wb_cyc[slow] - fire_cyc[slow], 12);
      end
    end else begin
      chk("wb_count", wb_cyc.size(), 12);
    end
    // DONE must hold without done_rdy and ignore start requests.
    for (int i = 0; i < 4; i++) begin
      bus.start_val = 1'b1;
      @(negedge clk);
      chk("done_hold", int'(bus.done_val), 1);
      chk("start_ignored", int'(bus.start_rdy), 0);
      @(posedge clk);
      #1;
    end
    bus.start_val = 1'b0;
    chk("no_fire_in_done", fire_count, 12);
    bus.done_rdy = 1'b1;
    @(posedge clk);
    #1;
    bus.done_rdy = 1'b0;
    @(negedge clk);
    chk("idle_after_ack", int'(bus.start_rdy), 1);
    chk("busy_after_ack", int'(bus.busy), 0);
    chk("done_after_ack", int'(bus.done_val), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    reset           = 1'b1;
    bus.start_val   = 1'b0;
    bus.cmd_rdy     = 1'b1;
    bus.done_rdy    = 1'b0;
    bus16.start_val = 1'b0;
    bus16.cmd_rdy   = 1'b1;
    bus16.done_rdy  = 1'b0;
    bus16.wb_val    = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state.
    chk("rst_start_rdy", int'(bus.start_rdy), 1);
    chk("rst_cmd_val",   int'(bus.cmd_val),   0);
    chk("rst_done_val",  int'(bus.done_val),  0);
    chk("rst_busy",      int'(bus.busy),      0);
    chk("rst_err",       int'(bus.err),       0);
    chk("rst_fields",    int'(bus.cmd_addr_a) + int'(bus.cmd_addr_b)
        + int'(bus.cmd_twiddle) + int'(bus.cmd_stage), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // In-flight limit on the 16-point instance (8 butterflies per stage).
    bus16.start_val = 1'b1;
    @(posedge clk);
    #1;
    bus16.start_val = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("limit_fires", fires16, 4);
    chk("limit_cmd_val", int'(bus16.cmd_val), 0);
    bus16.wb_val = 1'b1;
    @(posedge clk);
    #1;
    bus16.wb_val = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("one_more_fire", fires16, 5);
    chk("limit_cmd_val2", int'(bus16.cmd_val), 0);
    // Second pulse lands on the cycle of the resulting fire: count unchanged,
    // so exactly one further fire follows.
    bus16.wb_val = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus16.wb_val = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("simul_fire_wb", fires16, 7);
    chk("limit_cmd_val3", int'(bus16.cmd_val), 0);

    // Full frame, then backpressure mid-stage-1, then a late stage-0 write-back.
    run_frame(-1, -1, 1'b1);
    run_frame(5, -1, 1'b0);
    run_frame(-1, 3, 1'b0);

    // Reset in stage 1 with 3 butterflies outstanding.
    fire_count = 0;
    fire_cyc.delete();
    wb_cyc.delete();
    wb_due.delete();
    done_cyc   = -1;
    slow_fire  = -1;
    auto_limit = 4;
    push_frame();
    start_frame();
    hit = 1'b0;
    for (int n = 0; n < 100 && !hit; n++) begin
      @(posedge clk);
      #1;
      if (fire_count >= 7) begin
        hit = 1'b1;
        bus.cmd_rdy = 1'b0;
      end
    end
    chk("pre_reset_fires", fire_count, 7);
    chk("pre_reset_busy", int'(bus.busy), 1);
    reset = 1'b1;
    #2;
    chk("abort_start_rdy", int'(bus.start_rdy), 1);
    chk("abort_busy",      int'(bus.busy),      0);
    chk("abort_cmd_val",   int'(bus.cmd_val),   0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.cmd_rdy = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("post_rst_err", int'(bus.err), 0);
    chk("post_rst_idle", int'(bus.start_rdy), 1);
    wb_due.push_back(cyc + 1);
    @(negedge clk);
    @(negedge clk);
    chk("spurious_err", int'(bus.err), 1);
    repeat (3) @(negedge clk);
    chk("err_sticky", int'(bus.err), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
